byte_bus_responder: RTL
=======================

Name: byte_bus_responder

Overview:
- Target end of the 8-bit-lane CPU bus. Receives the CPU-side frame: 4 address bytes and 4 write-data bytes on two byte lanes, then a direction flag.
- On read frames, drives 4 read-data bytes back on the shared data lane.
- Backed by an internal DEPTH x 32 word memory. Sits on the board/tile side opposite the CPU handler and acts as its external memory.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..256
- AW, log2(DEPTH), word-index width; derived, do not override

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_sync  in  1  high for one cycle during slot 0, the cycle before address byte 0
- bus_a  in  8  address/flag lane from the CPU handler
- bus_d_in  in  8  write-data lane from the CPU handler
- bus_d_out  out  8  read-data lane to the CPU handler
- bus_d_oe  out  1  1 = responder drives the data lane
- wr_commit  out  1  one-cycle pulse after a memory write
- frame_done  out  1  one-cycle pulse after a complete frame
- frame_abort  out  1  one-cycle pulse when a frame is restarted mid-flight
- addr_err  out  1  one-cycle pulse on an out-of-range access (macro only; else tied 0)

Behaviour:
- Slot counter s in 0..9. "Slot k" = the cycle where s==k. Inputs are sampled at the rising edge ending the slot.
- Counter rules:
  - frame_sync sampled high -> s=1 next cycle, regardless of current s.
  - s in 1..8 -> s+1.
  - s==9 -> 0.
  - s==0 without sync -> stay 0.
- Slots 1-4: addr_q[8k-1:8k-8] <= bus_a and wdat_q[8k-1:8k-8] <= bus_d_in, where k = s, little-endian byte order.
- Slot 5: wr_q <= bus_a[0] (1 = write, 0 = read); bus_a[7:1] ignored.
- Word index = addr_q[AW+1:2]; addr_q[1:0] ignored.
- Write (end of slot 5, wr bit 1): mem[idx] <= wdat_q; wr_commit=1 during slot 6.
- Read (end of slot 5, wr bit 0): rsh <= mem[idx]. Only the read of a read frame drives the lane.
- Read-data drive:
  - bus_d_out = rsh[7:0] in slot 6, [15:8] in slot 7, [23:16] in slot 8, [31:24] in slot 9.
  - Output is registered, loaded at the end of the preceding slot.
- bus_d_oe = 1 only in slots 6-9 of a read frame. Otherwise 0 and bus_d_out = 0. The responder never drives during write frames; the CPU owns the lane for the whole write frame.
- frame_done = 1 in the cycle after slot 9, i.e. the first s==0 cycle or a new slot 1.
- Mid-frame sync:
  - frame_sync arriving while s in 1..9 aborts the current frame.
  - If the abort lands before the slot-5 edge: no write occurs.
  - If it lands after: the write already done stays done, and read drive stops immediately (bus_d_oe=0 next cycle).
  - frame_abort=1 during the new slot 1. frame_done is not pulsed for the aborted frame.
- Back-to-back frames: sync during slot 9 is legal, not an abort. frame_done and new slot 1 coincide.
- Reset:
  - s=0; addr_q, wdat_q, rsh, wr_q = 0; all outputs 0; memory cleared to 0.
  - rst wins over a same-edge write: no write occurs.
  - Reset mid-frame discards the frame with no pulses.
- Address aliasing without the macro: addr_q[31:AW+2] ignored; address wraps modulo 4*DEPTH bytes.

Optional Feature:
- ADDR_RANGE_CHK_EN defined:
  - Access is out of range if addr_q[31:AW+2] != 0.
  - Out-of-range write: dropped, no wr_commit.
  - Out-of-range read: returns 32'h0000_0000 with normal bus_d_oe timing.
  - addr_err=1 during slot 6 in both cases.
- ADDR_RANGE_CHK_EN undefined: aliasing as above; addr_err tied 0.

Test Plan:
- Reset, then idle 20 cycles without sync -> s stays 0, bus_d_oe=0, all pulses 0, read of word 0 returns 0x00000000.
- Write frame addr 0x00000008, data 0xA1B2C3D4, flag 1 -> wr_commit in slot 6, bus_d_oe stays 0; then read frame addr 0x00000008 -> bus_d_out D4,C3,B2,A1 in slots 6-9 with bus_d_oe=1, frame_done after slot 9.
- Back-to-back: sync in slot 9 of a read frame, followed by a write to word 3 -> frame_done and slot 1 coincide, no abort, write lands.
- Sync asserted in slot 3 of a write frame to word 1 -> frame_abort in the new slot 1, word 1 unchanged, no wr_commit.
- With DEPTH=16 and no macro: write 0x12345678 to addr 0x00000044 -> read of addr 0x00000004 returns 0x12345678. With ADDR_RANGE_CHK_EN: the same write is dropped with addr_err in slot 6, and a read of addr 0x00000044 returns 0x00000000.
- rst asserted in slot 5 of a write frame to word 2 -> word 2 remains 0, s=0, no pulses.

Source files
------------

// File: rtl/byte_bus_responder.sv
// Bus-target responder: collects a 10-slot byte-lane frame and reads/writes an internal DEPTH x 32 memory.
// Optional ADDR_RANGE_CHK_EN flags and suppresses accesses whose upper address bits are non-zero.
module byte_bus_responder #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  input  logic [7:0] bus_a,
  input  logic [7:0] bus_d_in,
  output logic [7:0] bus_d_out,
  output logic       bus_d_oe,
  output logic       wr_commit,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       addr_err
);

  logic [3:0]    slot;
  logic [3:0]    slot_next;
  logic [31:0]   addr_q;
  logic [31:0]   wdat_q;
  logic [31:0]   rsh;
  logic          wr_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   rd_word;
  logic          capture;
  logic          decide;
  logic          do_write;
  logic          do_read;
  logic          mid_frame;
  logic          unused_bits;

  assign idx = addr_q[AW+1:2];

`ifdef ADDR_RANGE_CHK_EN
  assign in_range    = (addr_q[31:AW+2] == '0);
  assign unused_bits = ^addr_q[1:0];
`else
  assign in_range    = 1'b1;
  assign unused_bits = ^{addr_q[31:AW+2], addr_q[1:0]};
`endif

  assign rd_word = in_range ? mem[idx] : 32'h0000_0000;

  // slot counter state register
  always_ff @(posedge clk) begin
    if (rst) slot <= 4'd0;
    else     slot <= slot_next;
  end

  always_comb begin
    slot_next = 4'd0;
    if (frame_sync)                         slot_next = 4'd1;
    else if (slot >= 4'd1 && slot <= 4'd8) slot_next = slot + 4'd1;
  end

  // A sync sampled at the slot-5 edge restarts the frame before the access is decided.
  always_comb begin
    capture   = (slot >= 4'd1) && (slot <= 4'd4);
    decide    = (slot == 4'd5) && !frame_sync;
    do_write  = decide && bus_a[0] && in_range;
    do_read   = decide && !bus_a[0];
    mid_frame = frame_sync && (slot >= 4'd1) && (slot <= 4'd8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wdat_q <= '0;
      rsh    <= '0;
      wr_q   <= 1'b0;
    end else begin
      if (capture) begin
        case (slot)
          4'd1:    begin addr_q[7:0]   <= bus_a; wdat_q[7:0]   <= bus_d_in; end
          4'd2:    begin addr_q[15:8]  <= bus_a; wdat_q[15:8]  <= bus_d_in; end
          4'd3:    begin addr_q[23:16] <= bus_a; wdat_q[23:16] <= bus_d_in; end
          default: begin addr_q[31:24] <= bus_a; wdat_q[31:24] <= bus_d_in; end
        endcase
      end
      if (decide)  wr_q <= bus_a[0];
      if (do_read) rsh  <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[idx] <= wdat_q;
    end
  end

  // Registered outputs; read drive is rebuilt each cycle so an abort drops it at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_d_out   <= 8'h00;
      bus_d_oe    <= 1'b0;
      wr_commit   <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      wr_commit   <= do_write;
      frame_done  <= (slot == 4'd9);
      frame_abort <= mid_frame;
      bus_d_out   <= 8'h00;
      bus_d_oe    <= 1'b0;
      if (do_read) begin
        bus_d_out <= rd_word[7:0];
        bus_d_oe  <= 1'b1;
      end else if (bus_d_oe && !frame_sync && !wr_q) begin
        case (slot)
          4'd6: begin bus_d_out <= rsh[15:8];  bus_d_oe <= 1'b1; end
          4'd7: begin bus_d_out <= rsh[23:16]; bus_d_oe <= 1'b1; end
          4'd8: begin bus_d_out <= rsh[31:24]; bus_d_oe <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

`ifdef ADDR_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else     addr_err <= decide && !in_range;
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule
